sgmii_rx_gmii: RTL
==================

SGMII_RX_GMII -- requirements
Module: sgmii_rx_gmii

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the frame and error statistics counters.
REQ-002 SHALL have port clk  input  1  the single clock for all logic (the read-side clock of the symbol FIFO).
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sym_in  input  9  FIFO head symbol; bit 8 = K flag, [7:0] = octet; combinationally valid whenever empty=0.
REQ-005 SHALL have port empty  input  1  FIFO empty flag.
REQ-006 SHALL have port pop  output  1  FIFO pop; the symbol is consumed when pop=1.
REQ-007 SHALL have port rate  input  2  link speed: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 = reserved, treated as 1000.
REQ-008 SHALL have port gmii_rx_stb  output  1  one-cycle qualifier for a new GMII beat.
REQ-009 SHALL have port gmii_rxd  output  8  GMII receive data.
REQ-010 SHALL have port gmii_rx_dv  output  1  GMII data valid.
REQ-011 SHALL have port gmii_rx_er  output  1  GMII receive error.
REQ-012 SHALL have port frame_cnt  output  CNT_W  count of frames terminated by /T/; saturating.
REQ-013 SHALL have port err_cnt  output  CNT_W  count of frames containing an error; saturating.

Function
REQ-014 SHALL drive pop = !empty combinationally, so a symbol is accepted on every cycle with empty=0.
REQ-015 SHALL decode K symbols as follows: 0xFB = /S/, 0xFD = /T/, 0xFE = /E/, 0xBC = /K28.5/; any other K value is "other K".
REQ-016 SHALL decimate accepted symbols by a replication factor of 1, 10 or 100 for rate 1000, 100 or 10, using a symbol counter that counts 0..factor-1 and wraps.
REQ-017 SHALL process only accepted symbols with counter = 0; other accepted symbols are consumed and discarded.
REQ-018 SHALL, when /S/ is accepted in IDLE, force the counter to 0 and process that symbol, so decimation is aligned to the frame start.
REQ-019 SHALL sample rate only in IDLE; a rate change during a frame takes effect at the next IDLE.
REQ-020 SHALL implement states IDLE, FRAME and DROP.
REQ-021 IDLE: on /S/ SHALL output rxd=0x55, dv=1, er=0 and go to FRAME; all other symbols SHALL be discarded with no beat issued.
REQ-022 FRAME, data symbol (K=0): SHALL output rxd=octet, dv=1, er=0.
REQ-023 FRAME, /T/: SHALL output a beat with dv=0, er=0, rxd=0x00, increment frame_cnt and go to IDLE.
REQ-024 FRAME, /E/: SHALL output rxd=0xFE, dv=1, er=1, mark the frame as errored and stay in FRAME.
REQ-025 FRAME, /S/ or other K: SHALL output dv=1, er=1, rxd=0xFE and go to DROP.
REQ-026 DROP: SHALL issue no beats until /K28.5/ is accepted; it then SHALL output a beat with dv=0, er=0 and go to IDLE.
REQ-027 SHALL increment err_cnt by 1 for each frame that reaches DROP or that ends with /T/ after any /E/, and at most once per frame.
REQ-028 SHALL register all GMII outputs; latency is one clock from accepting a processed symbol to gmii_rx_stb=1.
REQ-029 SHALL pulse gmii_rx_stb for exactly one cycle per beat; rxd/dv/er SHALL hold their values between beats.
REQ-030 SHALL saturate frame_cnt and err_cnt at all-ones; they are never cleared except by reset.
REQ-031 SHALL, when empty=1, hold the state and the symbol counter unchanged.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, symbol counter 0, gmii_rx_stb=0, gmii_rxd=0x00, gmii_rx_dv=0, gmii_rx_er=0, frame_cnt=0, err_cnt=0 and the errored-frame flag cleared.
REQ-033 Reset assertion mid-frame SHALL abort the frame with no further beats; after release the block SHALL wait in IDLE for a new /S/.

Structure
REQ-034 SHALL take the K-code constants (0xFB, 0xFD, 0xFE, 0xBC, 0xF7), the rate encodings and the GMII preamble value 0x55 from shared package sgmii_pkg.
REQ-035 SHALL place the decimation counter in sub-module sgmii_rate_div, with inputs clk, rst_n, adv, align and factor and output take; the state machine stays in the top module.

Verification
REQ-036 Rate 1000, stream /K28.5/, /S/, D 0x11, D 0x22, /T/ with empty=0 throughout -> beats (0x55,dv1), (0x11,dv1), (0x22,dv1), (dv0), each one cycle after the symbol; frame_cnt=1.
REQ-037 Rate 100, each symbol of /S/, 0xA5, /T/ replicated 10x -> exactly 3 beats, 10 cycles apart: 0x55, 0xA5, dv0.
REQ-038 Rate 10, 100x replication with 5 random empty=1 cycles inserted -> same 3 beats as REQ-037, no duplicated or skipped beats.
REQ-039 Rate 1000, /S/, 0x01, /E/, 0x02, /T/ -> the /E/ beat is rxd=0xFE, dv1, er1; frame_cnt=1 and err_cnt=1.
REQ-040 Rate 1000, /S/, 0x01, /K28.5/, 0x33, /K28.5/ -> beat er=1 at the first /K28.5/, no beat for 0x33, a dv0 beat at the second /K28.5/; err_cnt=1, frame_cnt=0.
REQ-041 rst_n pulsed low mid-frame after 0x01 -> all outputs 0 immediately; a following 0x02, /T/ produce no beats; the next /S/ produces a 0x55 beat.

Source files
------------

// File: rtl/sgmii_pkg.sv
// Shared constants and types for the SGMII receive to GMII path.
package sgmii_pkg;

  // 8b/10b control codes as seen on the decoded symbol stream
  localparam logic [7:0] K_SOP   = 8'hFB;  // /S/ start of packet
  localparam logic [7:0] K_EOP   = 8'hFD;  // /T/ end of packet
  localparam logic [7:0] K_ERR   = 8'hFE;  // /E/ error propagation
  localparam logic [7:0] K_COMMA = 8'hBC;  // /K28.5/ idle comma
  localparam logic [7:0] K_EXT   = 8'hF7;  // /R/ carrier extend

  localparam logic [1:0] RATE_10   = 2'b00;
  localparam logic [1:0] RATE_100  = 2'b01;
  localparam logic [1:0] RATE_1000 = 2'b10;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_ERR_OCT  = 8'hFE;

  localparam int FACTOR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } rx_state_t;

  // Symbol replication factor for a link speed; the reserved code runs at 1000
  function automatic logic [FACTOR_W-1:0] rate_factor(input logic [1:0] rate);
    case (rate)
      RATE_100: return FACTOR_W'(10);
      RATE_10:  return FACTOR_W'(100);
      default:  return FACTOR_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/sgmii_rate_div.sv
// Symbol decimator: passes one accepted symbol out of every 'factor'.
module sgmii_rate_div
  import sgmii_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic                align,
  input  logic [FACTOR_W-1:0] factor,
  output logic                take
);

  logic [FACTOR_W-1:0] cnt;
  logic [FACTOR_W-1:0] cnt_base;
  logic [FACTOR_W-1:0] cnt_inc;

  // align treats the current symbol as slot 0 so decimation locks to the frame start
  assign cnt_base = align ? '0 : cnt;
  assign cnt_inc  = cnt_base + FACTOR_W'(1);
  assign take     = adv && (cnt_base == '0);

  // Slot counter advances only on accepted symbols and wraps at factor-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= (cnt_inc >= factor) ? '0 : cnt_inc;
    end
  end

endmodule

// File: rtl/sgmii_rx_gmii.sv
// Converts the decoded SGMII symbol stream into registered GMII receive beats.
//
// state | meaning
// IDLE  | between frames, waiting for /S/
// FRAME | forwarding frame octets until /T/
// DROP  | frame aborted, silent until /K28.5/
module sgmii_rx_gmii
  import sgmii_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       sym_in,
  input  logic             empty,
  output logic             pop,
  input  logic [1:0]       rate,
  output logic             gmii_rx_stb,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_er,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_t           state;
  logic                err_flag;
  logic                is_k;
  logic [7:0]          oct;
  logic                adv;
  logic                align;
  logic                take;
  logic [FACTOR_W-1:0] factor_q;
  logic [FACTOR_W-1:0] factor_eff;

  assign pop  = !empty;
  assign adv  = !empty;
  assign is_k = sym_in[8];
  assign oct  = sym_in[7:0];

  assign align      = adv && (state == ST_IDLE) && is_k && (oct == K_SOP);
  assign factor_eff = (state == ST_IDLE) ? rate_factor(rate) : factor_q;

  // Rate is tracked while idle and frozen for the duration of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      factor_q <= FACTOR_W'(1);
    end else begin
      factor_q <= factor_eff;
    end
  end

  sgmii_rate_div u_rate_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (adv),
    .align  (align),
    .factor (factor_eff),
    .take   (take)
  );

  // Frame state machine with registered GMII outputs and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      err_flag    <= 1'b0;
      gmii_rx_stb <= 1'b0;
      gmii_rxd    <= 8'h00;
      gmii_rx_dv  <= 1'b0;
      gmii_rx_er  <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      gmii_rx_stb <= 1'b0;
      if (take) begin
        case (state)
          ST_IDLE: begin
            if (is_k && oct == K_SOP) begin
              gmii_rx_stb <= 1'b1;
              gmii_rxd    <= GMII_PREAMBLE;
              gmii_rx_dv  <= 1'b1;
              gmii_rx_er  <= 1'b0;
              err_flag    <= 1'b0;
              state       <= ST_FRAME;
            end
          end
          ST_FRAME: begin
            gmii_rx_stb <= 1'b1;
            if (!is_k) begin
              gmii_rxd   <= oct;
              gmii_rx_dv <= 1'b1;
              gmii_rx_er <= 1'b0;
            end else if (oct == K_EOP) begin
              gmii_rxd   <= 8'h00;
              gmii_rx_dv <= 1'b0;
              gmii_rx_er <= 1'b0;
              state      <= ST_IDLE;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
              if (err_flag && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else if (oct == K_ERR) begin
              gmii_rxd   <= GMII_ERR_OCT;
              gmii_rx_dv <= 1'b1;
              gmii_rx_er <= 1'b1;
              err_flag   <= 1'b1;
            end else begin
              // /S/ or any unexpected K inside a frame aborts it; counted once here
              gmii_rxd   <= GMII_ERR_OCT;
              gmii_rx_dv <= 1'b1;
              gmii_rx_er <= 1'b1;
              state      <= ST_DROP;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
          end
          ST_DROP: begin
            if (is_k && oct == K_COMMA) begin
              gmii_rx_stb <= 1'b1;
              gmii_rxd    <= 8'h00;
              gmii_rx_dv  <= 1'b0;
              gmii_rx_er  <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
